// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// flush and NOP masking. Optional perf counters under `PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC8_W   = 32,
  parameter int unsigned PC_W    = 30,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h00000000)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC8_W-1:0]   in_pc8,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC8_W-1:0]   out_pc8,
  output logic [PC_W-1:0]    out_pc
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  localparam int unsigned ENTRY_W = INSTR_W + PC8_W + PC_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [ENTRY_W-1:0] main_q;
  logic [ENTRY_W-1:0] skid_q;
  logic [ENTRY_W-1:0] in_entry;
  logic               accept;
  logic               pop;
  logic               load_main;
  logic               load_skid;
  logic               move_skid;

  assign in_entry = {in_instr, in_pc8, in_pc};
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // State register; reset dominates flush.
  always_ff @(posedge clock) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // Next state and storage steering; flush overrides accept and pop.
  always_comb begin
    state_next = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) begin
          state_next = ONE;
          load_main  = 1'b1;
        end
        ONE: begin
          if (accept && pop) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_next = TWO;
            load_skid  = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_next = ONE;
          move_skid  = 1'b1;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Outputs: handshake from registered state, payload masked when invalid.
  always_comb begin
    in_ready  = (state != TWO);
    out_valid = (state != EMPTY);
    out_instr = NOP_INSTR;
    out_pc8   = '0;
    out_pc    = '0;
    if (out_valid) begin
      out_instr = main_q[ENTRY_W-1 -: INSTR_W];
      out_pc8   = main_q[PC_W +: PC8_W];
      out_pc    = main_q[PC_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)      main_q <= in_entry;
      else if (move_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= in_entry;
      else if (move_skid) skid_q <= '0;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_hit;
  logic flush_hit;

  assign stall_hit = out_valid & ~out_ready;
  assign flush_hit = flush & ((state != EMPTY) | in_valid);

  // Saturating counters, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (stall_hit && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush_hit && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, back-pressure, flush,
// reset-vs-flush, and perf counters when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_skid;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc8;
  logic [29:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc8;
  logic [29:0] out_pc;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_skid dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc8    (in_pc8),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc8   (out_pc8),
    .out_pc    (out_pc)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pc8_of(input logic [31:0] instr);
    return instr + 32'd8;
  endfunction

  function automatic logic [29:0] pc_of(input logic [31:0] instr);
    return 30'(instr >> 2);
  endfunction

  task automatic drive(input logic v, input logic [31:0] instr);
    in_valid = v;
    in_instr = instr;
    in_pc8   = pc8_of(instr);
    in_pc    = pc_of(instr);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_entry(input string tag, input logic [31:0] instr);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_instr"}, 64'(out_instr), 64'(instr));
    check({tag, "_pc8"},   64'(out_pc8),   64'(pc8_of(instr)));
    check({tag, "_pc"},    64'(out_pc),    64'(pc_of(instr)));
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_instr"}, 64'(out_instr), 64'h0);
    check({tag, "_pc8"},   64'(out_pc8),   64'h0);
    check({tag, "_pc"},    64'(out_pc),    64'h0);
    check({tag, "_ready"}, 64'(in_ready),  64'd1);
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0);

    // Reset for two cycles, then idle
    step();
    step();
    reset = 1'b0;
    expect_empty("rst");
    step();
    expect_empty("idle");

    // Streaming with no back-pressure
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h20080001 + 32'(i));
      step();
      expect_entry($sformatf("strm%0d", i), 32'h20080001 + 32'(i));
      check($sformatf("strm%0d_ready", i), 64'(in_ready), 64'd1);
    end
    drive(1'b0, 32'h0);
    step();
    expect_empty("strm_drain");

    // Back-pressure fills the skid entry
    out_ready = 1'b0;
    drive(1'b1, 32'hA);
    step();
    expect_entry("bp_a", 32'hA);
    check("bp_a_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 32'hB);
    step();
    expect_entry("bp_hold1", 32'hA);
    check("bp_two_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'hC);
    step();
    expect_entry("bp_hold2", 32'hA);
    check("bp_hold2_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    expect_entry("bp_b", 32'hB);
    check("bp_b_ready", 64'(in_ready), 64'd1);
    step();
    expect_entry("bp_c", 32'hC);
    drive(1'b0, 32'h0);
    step();
    expect_empty("bp_drain");

    // Flush while TWO, with a concurrent input
    out_ready = 1'b0;
    drive(1'b1, 32'hA);
    step();
    drive(1'b1, 32'hB);
    step();
    check("fl_two_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'hC);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    expect_empty("fl_after");
    out_ready = 1'b1;
    step();
    expect_empty("fl_no_c");

    // Reset together with flush and input in ONE
    out_ready = 1'b0;
    drive(1'b1, 32'hD);
    step();
    expect_entry("rf_one", 32'hD);
    reset = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'hE);
    step();
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0);
    expect_empty("rf_after");

`ifdef PIPE_STAGE_PERF_EN
    check("perf_rst_stall", 64'(stall_cnt), 64'd0);
    check("perf_rst_flush", 64'(flush_cnt), 64'd0);
    // Flush with nothing to squash is not counted
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("perf_idle_flush", 64'(flush_cnt), 64'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'hF);
    step();
    drive(1'b0, 32'h0);
    repeat (5) step();
    check("perf_stall5", 64'(stall_cnt), 64'd5);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("perf_flush1", 64'(flush_cnt), 64'd1);
    check("perf_stall_keep", 64'(stall_cnt), 64'd5);
    expect_empty("perf_after_flush");
    // Drive the stall counter into saturation
    out_ready = 1'b0;
    drive(1'b1, 32'h11);
    step();
    drive(1'b0, 32'h0);
    repeat (65530) step();
    check("perf_stall_max", 64'(stall_cnt), 64'hFFFF);
    step();
    check("perf_stall_sat", 64'(stall_cnt), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
